// File: rtl/reset_sequencer.sv
// PLL-qualified reset sequencer: filters lock, holds all resets, then releases
// NUM_STAGES active-high resets in index order; re-sequences on lock loss or soft reset.
module reset_sequencer #(
   parameter int unsigned NUM_STAGES  = 3,
   parameter int unsigned HOLD_CYCLES = 10,
   parameter int unsigned STAGE_GAP   = 4,
   parameter int unsigned LOCK_FILTER = 16,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  locked,
   input  logic                  soft_rst,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  all_released,
   output logic [7:0]            lock_lost_count
);

   localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_FILTER - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);

   typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

   state_t                  state, state_nxt;
   logic [CNT_WIDTH-1:0]    timer, timer_nxt;
   logic [NUM_STAGES-1:0]   rst_nxt, rst_shift;
   logic                    all_nxt;
   logic [7:0]              cnt_nxt;
   logic                    sync_meta, locked_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         sync_meta <= locked;
         locked_s  <= sync_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= WAIT_LOCK;
         timer           <= '0;
         rst_out         <= '1;
         all_released    <= 1'b0;
         lock_lost_count <= '0;
      end else begin
         state           <= state_nxt;
         timer           <= timer_nxt;
         rst_out         <= rst_nxt;
         all_released    <= all_nxt;
         lock_lost_count <= cnt_nxt;
      end
   end

   // Stages release strictly in index order, so the next pattern is a left shift
   // of the current one; the sequence is complete once the shift empties the vector.
   assign rst_shift = rst_out << 1;

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      rst_nxt   = rst_out;
      all_nxt   = all_released;
      cnt_nxt   = lock_lost_count;
      case (state)
         HOLD, RELEASE, RUN: begin
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               timer_nxt = '0;
               rst_nxt   = '1;
               all_nxt   = 1'b0;
               cnt_nxt   = (lock_lost_count == 8'hFF) ? 8'hFF : lock_lost_count + 8'd1;
            end else if (soft_rst) begin
               state_nxt = HOLD;
               timer_nxt = '0;
               rst_nxt   = '1;
               all_nxt   = 1'b0;
            end else if (state != RUN) begin
               if ((state == HOLD && timer == HOLD_LAST) ||
                   (state == RELEASE && timer == GAP_LAST)) begin
                  timer_nxt = '0;
                  rst_nxt   = rst_shift;
                  if (rst_shift == '0) begin
                     state_nxt = RUN;
                     all_nxt   = 1'b1;
                  end else begin
                     state_nxt = RELEASE;
                  end
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
         end
         default: begin
            rst_nxt = '1;
            all_nxt = 1'b0;
            if (!locked_s) begin
               timer_nxt = '0;
            end else if (timer == LOCK_LAST) begin
               state_nxt = HOLD;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
      endcase
   end

endmodule
